// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
//   Time-of-day counter kept as packed BCD (hour:min:sec). The counter advances
//   one second for every TICKS_PER_SEC rising edges of the tick input. It
//   provides a valid/ready load port for setting the time, and registered
//   one-cycle strobes for downstream display and alarm logic. The tick input is
//   treated as data and is edge-detected inside the clock domain.
//
// Parameters
//   TICKS_PER_SEC  tick rising edges per one-second advance (1..255)
//   HOURS_PER_DAY  24 (hours 00..23) or 12 (hours 01..12)
//
// Ports
//   clock, reset        system clock, asynchronous active-high reset
//   tick                divider output, rising-edge detected
//   set_valid/ready     load handshake; ready drops for one cycle after a load
//   set_hour/min/sec    BCD time to load
//   set_err             one-cycle strobe: the accepted load was invalid
//   hour/min/sec        current BCD time
//   sec_stb             one-cycle strobe on every second advance
//   min_carry           one-cycle strobe when seconds wrap 59 -> 00
//   day_carry           one-cycle strobe when the hour wraps
//
// Optional feature (macro BCD_TIME_ALARM_EN)
//   alarm_hour/min/arm  alarm compare time and enable
//   alarm_hit           one-cycle strobe, coincident with min_carry, when the
//                       new hour:min equals the armed alarm time
// ---------------------------------------------------------------------------
module bcd_time_counter #(
    parameter int unsigned TICKS_PER_SEC = 4,
    parameter int unsigned HOURS_PER_DAY = 24
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       set_valid,
    output logic       set_ready,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    output logic       set_err,
    output logic [7:0] hour,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic       sec_stb,
    output logic       min_carry,
    output logic       day_carry
`ifdef BCD_TIME_ALARM_EN
    ,
    input  logic [7:0] alarm_hour,
    input  logic [7:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm_hit
`endif
);

    localparam logic [7:0] PRESC_MAX = 8'(TICKS_PER_SEC - 1);
    localparam logic [7:0] HOUR_RST  = (HOURS_PER_DAY == 12) ? 8'h12 : 8'h00;

    // {wrap, next} for a 00..59 BCD field
    function automatic logic [8:0] inc_bcd59(input logic [7:0] v);
        if (v == 8'h59)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    // {wrap, next} for the hour field in the configured mode
    function automatic logic [8:0] inc_hour(input logic [7:0] v);
        if (HOURS_PER_DAY == 12 && v == 8'h12)
            return {1'b1, 8'h01};
        else if (HOURS_PER_DAY != 12 && v == 8'h23)
            return {1'b1, 8'h00};
        else if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        else
            return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic load_ok(input logic [7:0] h,
                                     input logic [7:0] m,
                                     input logic [7:0] s);
        logic digits_ok;
        logic hour_ok;
        digits_ok = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
                    (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9) &&
                    (s[7:4] <= 4'd9) && (s[3:0] <= 4'd9);
        // With every digit legal, packed BCD orders like the decimal value.
        if (HOURS_PER_DAY == 12)
            hour_ok = (h != 8'h00) && (h <= 8'h12);
        else
            hour_ok = (h <= 8'h23);
        return digits_ok && (s[7:4] <= 4'd5) && (m[7:4] <= 4'd5) && hour_ok;
    endfunction

    logic       tick_q;
    logic [7:0] presc_q,     presc_d;
    logic [7:0] sec_q,       sec_d;
    logic [7:0] min_q,       min_d;
    logic [7:0] hour_q,      hour_d;
    logic       sec_stb_q,   sec_stb_d;
    logic       min_carry_q, min_carry_d;
    logic       day_carry_q, day_carry_d;
    logic       set_err_q,   set_err_d;
    logic       ready_q,     ready_d;
`ifdef BCD_TIME_ALARM_EN
    logic       alarm_hit_q, alarm_hit_d;
`endif

    logic       tick_edge;
    logic       xfer;
    logic [8:0] sec_inc;
    logic [8:0] min_inc;
    logic [8:0] hour_inc;

    always_comb begin
        tick_edge   = tick & ~tick_q;
        xfer        = set_valid & ready_q;
        sec_inc     = inc_bcd59(sec_q);
        min_inc     = inc_bcd59(min_q);
        hour_inc    = inc_hour(hour_q);

        presc_d     = presc_q;
        sec_d       = sec_q;
        min_d       = min_q;
        hour_d      = hour_q;
        sec_stb_d   = 1'b0;
        min_carry_d = 1'b0;
        day_carry_d = 1'b0;
        set_err_d   = 1'b0;
        // One busy cycle after every transfer caps loads at one per two cycles.
        ready_d     = ~xfer;
`ifdef BCD_TIME_ALARM_EN
        alarm_hit_d = 1'b0;
`endif

        if (xfer) begin
            // A load always clears the prescaler and swallows a coincident edge.
            presc_d = '0;
            if (load_ok(set_hour, set_min, set_sec)) begin
                hour_d = set_hour;
                min_d  = set_min;
                sec_d  = set_sec;
            end else begin
                set_err_d = 1'b1;
            end
        end else if (tick_edge) begin
            if (presc_q == PRESC_MAX) begin
                presc_d   = '0;
                sec_stb_d = 1'b1;
                sec_d     = sec_inc[7:0];
                if (sec_inc[8]) begin
                    min_carry_d = 1'b1;
                    min_d       = min_inc[7:0];
                    if (min_inc[8]) begin
                        hour_d      = hour_inc[7:0];
                        day_carry_d = hour_inc[8];
                    end
`ifdef BCD_TIME_ALARM_EN
                    alarm_hit_d = alarm_arm && (hour_d == alarm_hour) &&
                                  (min_d == alarm_min);
`endif
                end
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tick_q      <= 1'b0;
            presc_q     <= '0;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            hour_q      <= HOUR_RST;
            sec_stb_q   <= 1'b0;
            min_carry_q <= 1'b0;
            day_carry_q <= 1'b0;
            set_err_q   <= 1'b0;
            ready_q     <= 1'b0;
`ifdef BCD_TIME_ALARM_EN
            alarm_hit_q <= 1'b0;
`endif
        end else begin
            tick_q      <= tick;
            presc_q     <= presc_d;
            sec_q       <= sec_d;
            min_q       <= min_d;
            hour_q      <= hour_d;
            sec_stb_q   <= sec_stb_d;
            min_carry_q <= min_carry_d;
            day_carry_q <= day_carry_d;
            set_err_q   <= set_err_d;
            ready_q     <= ready_d;
`ifdef BCD_TIME_ALARM_EN
            alarm_hit_q <= alarm_hit_d;
`endif
        end
    end

    assign set_ready = ready_q;
    assign set_err   = set_err_q;
    assign hour      = hour_q;
    assign min       = min_q;
    assign sec       = sec_q;
    assign sec_stb   = sec_stb_q;
    assign min_carry = min_carry_q;
    assign day_carry = day_carry_q;
`ifdef BCD_TIME_ALARM_EN
    assign alarm_hit = alarm_hit_q;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// ---------------------------------------------------------------------------
// tb_bcd_time_counter
//   Self-checking bench for bcd_time_counter (TICKS_PER_SEC=4, 24-hour mode).
//   Each driven cycle pushes the expected outputs onto a scoreboard queue,
//   and these are popped and compared after the following clock edge.
//   Alarm checks are compiled in when BCD_TIME_ALARM_EN is defined.
// ---------------------------------------------------------------------------
module tb_bcd_time_counter;

    localparam int TPS = 4;
`ifdef BCD_TIME_ALARM_EN
    localparam bit ALARM_BUILD = 1'b1;
`else
    localparam bit ALARM_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] hour;
        logic [7:0] min;
        logic [7:0] sec;
        logic       sec_stb;
        logic       min_carry;
        logic       day_carry;
        logic       set_err;
        logic       set_ready;
        logic       alarm_hit;
    } obs_t;

    typedef struct {
        bit         tick;
        bit         valid;
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
    } stim_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       tick;
    logic       set_valid;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic [7:0] set_sec;
    logic       set_ready_w;
    logic       set_err_w;
    logic [7:0] hour_w;
    logic [7:0] min_w;
    logic [7:0] sec_w;
    logic       sec_stb_w;
    logic       min_carry_w;
    logic       day_carry_w;
    logic       alarm_hit_w;
    logic [7:0] alarm_hour;
    logic [7:0] alarm_min;
    logic       alarm_arm;

    always #5 clock = ~clock;

    bcd_time_counter #(
        .TICKS_PER_SEC(TPS),
        .HOURS_PER_DAY(24)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .tick      (tick),
        .set_valid (set_valid),
        .set_ready (set_ready_w),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .set_err   (set_err_w),
        .hour      (hour_w),
        .min       (min_w),
        .sec       (sec_w),
        .sec_stb   (sec_stb_w),
        .min_carry (min_carry_w),
        .day_carry (day_carry_w)
`ifdef BCD_TIME_ALARM_EN
        ,
        .alarm_hour(alarm_hour),
        .alarm_min (alarm_min),
        .alarm_arm (alarm_arm),
        .alarm_hit (alarm_hit_w)
`endif
    );

`ifndef BCD_TIME_ALARM_EN
    assign alarm_hit_w = 1'b0;
`endif

    obs_t obs;
    assign obs = {hour_w, min_w, sec_w, sec_stb_w, min_carry_w, day_carry_w,
                  set_err_w, set_ready_w, alarm_hit_w};

    obs_t  sb_q[$];
    stim_t stim_q[$];
    int    checks   = 0;
    int    failures = 0;

    // Reference model state
    bit         m_tick;
    bit         m_ready;
    int         m_presc;
    logic [7:0] m_h;
    logic [7:0] m_m;
    logic [7:0] m_s;

    function automatic int bcd2bin(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    function automatic bit load_valid(input logic [7:0] h, input logic [7:0] m,
                                      input logic [7:0] s);
        if (h[7:4] > 9 || h[3:0] > 9 || m[7:4] > 9 || m[3:0] > 9 ||
            s[7:4] > 9 || s[3:0] > 9)
            return 1'b0;
        return (bcd2bin(s) <= 59) && (bcd2bin(m) <= 59) && (bcd2bin(h) <= 23);
    endfunction

    task automatic model_reset();
        m_tick  = 1'b0;
        m_ready = 1'b0;
        m_presc = 0;
        m_h     = 8'h00;
        m_m     = 8'h00;
        m_s     = 8'h00;
    endtask

    // Outputs expected after the clock edge that samples stimulus st.
    function automatic obs_t model_cycle(input stim_t st);
        obs_t e;
        int   t;
        bit   xfer;
        bit   edge_seen;
        e         = '0;
        xfer      = st.valid && m_ready;
        edge_seen = st.tick && !m_tick;
        m_tick    = st.tick;
        if (xfer) begin
            m_presc = 0;
            if (load_valid(st.h, st.m, st.s)) begin
                m_h = st.h;
                m_m = st.m;
                m_s = st.s;
            end else begin
                e.set_err = 1'b1;
            end
        end else if (edge_seen) begin
            if (m_presc == TPS - 1) begin
                m_presc = 0;
                t = bcd2bin(m_h) * 3600 + bcd2bin(m_m) * 60 + bcd2bin(m_s) + 1;
                if (t == 86400) t = 0;
                m_h = bin2bcd(t / 3600);
                m_m = bin2bcd((t / 60) % 60);
                m_s = bin2bcd(t % 60);
                e.sec_stb   = 1'b1;
                e.min_carry = (t % 60 == 0);
                e.day_carry = (t == 0);
                e.alarm_hit = ALARM_BUILD && alarm_arm && e.min_carry &&
                              (m_h == alarm_hour) && (m_m == alarm_min);
            end else begin
                m_presc++;
            end
        end
        m_ready     = !xfer;
        e.hour      = m_h;
        e.min       = m_m;
        e.sec       = m_s;
        e.set_ready = m_ready;
        return e;
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++)
            stim_q.push_back('{1'b0, 1'b0, 8'h00, 8'h00, 8'h00});
    endfunction

    function automatic void add_hold(input int n);
        for (int i = 0; i < n; i++)
            stim_q.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
    endfunction

    function automatic void add_pulse(input int gap);
        stim_q.push_back('{1'b1, 1'b0, 8'h00, 8'h00, 8'h00});
        add_idle(gap - 1);
    endfunction

    function automatic void add_load(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s, input bit with_tick);
        stim_q.push_back('{with_tick, 1'b1, h, m, s});
        add_idle(1);
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive_cycle(input stim_t st);
        tick      = st.tick;
        set_valid = st.valid;
        set_hour  = st.h;
        set_min   = st.m;
        set_sec   = st.s;
        sb_q.push_back(model_cycle(st));
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        tick      = 1'b0;
        set_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        obs_t  exp;
        stim_t st;
        int    n;
        reset     = 1'b1;
        tick      = 1'b0;
        set_valid = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        exp = '0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h", obs, exp);
        end
        reset = 1'b0;
        stim_q.delete();
        add_idle(2);
        n = 0;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_release cycle %0d: got %h expected %h", n, obs, exp);
            end
            n++;
        end
    endtask

    task automatic test_tick_hold();
        obs_t  exp;
        stim_t st;
        int    n;
        int    stb_cnt;
        int    hold_stb;
        apply_reset();
        stim_q.delete();
        add_idle(1);
        add_hold(20);
        add_idle(3);
        add_pulse(4);
        add_pulse(4);
        add_pulse(4);
        n = 0; stb_cnt = 0; hold_stb = 0;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL tick_hold cycle %0d: got %h expected %h", n, obs, exp);
            end
            if (sec_stb_w === 1'b1) stb_cnt++;
            if (n <= 24 && sec_w !== 8'h00) hold_stb++;
            n++;
        end
        checks++;
        if (hold_stb != 0) begin
            failures++;
            $display("FAIL tick_hold_sec: nonzero sec in %0d cycles, required 0", hold_stb);
        end
        checks++;
        if (stb_cnt != 1 || sec_w !== 8'h01) begin
            failures++;
            $display("FAIL tick_hold_final: stb=%0d sec=%h required stb=1 sec=01", stb_cnt, sec_w);
        end
    endtask

    task automatic test_tick_count();
        obs_t  exp;
        stim_t st;
        int    n;
        int    stb_cnt;
        int    stb_at[2];
        apply_reset();
        stim_q.delete();
        add_idle(1);
        for (int k = 0; k < 8; k++) add_pulse(15);
        n = 0; stb_cnt = 0; stb_at[0] = -1; stb_at[1] = -1;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL tick_count cycle %0d: got %h expected %h", n, obs, exp);
            end
            if (sec_stb_w === 1'b1) begin
                if (stb_cnt < 2) stb_at[stb_cnt] = n;
                stb_cnt++;
            end
            n++;
        end
        // 4th rise driven at index 46, 8th at 106; strobe visible right after.
        checks++;
        if (stb_cnt != 2 || stb_at[0] != 46 || stb_at[1] != 106 || sec_w !== 8'h02) begin
            failures++;
            $display("FAIL tick_count_summary: stb=%0d at %0d,%0d sec=%h required 2 at 46,106 sec=02",
                     stb_cnt, stb_at[0], stb_at[1], sec_w);
        end
    endtask

    task automatic test_rollover();
        obs_t  exp;
        stim_t st;
        int    n;
        int    both;
        bit    saw59;
        stim_q.delete();
        add_load(8'h23, 8'h59, 8'h58, 1'b0);
        for (int k = 0; k < 8; k++) add_pulse(4);
        n = 0; both = 0; saw59 = 1'b0;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rollover cycle %0d: got %h expected %h", n, obs, exp);
            end
            if (min_carry_w === 1'b1 && day_carry_w === 1'b1) both++;
            if (sec_w === 8'h59) saw59 = 1'b1;
            n++;
        end
        checks++;
        if (both != 1 || !saw59 || {hour_w, min_w, sec_w} !== 24'h000000) begin
            failures++;
            $display("FAIL rollover_summary: carries=%0d saw59=%0d time=%h required 1 1 000000",
                     both, saw59, {hour_w, min_w, sec_w});
        end
    endtask

    task automatic test_load();
        obs_t  exp;
        stim_t st;
        int    n;
        int    errs;
        logic  rdy_after;
        logic  rdy_next;
        stim_q.delete();
        add_load(8'h24, 8'h00, 8'h00, 1'b0);
        add_load(8'h00, 8'h00, 8'h5A, 1'b0);
        add_load(8'h01, 8'h1A, 8'h00, 1'b0);
        add_load(8'h12, 8'h34, 8'h56, 1'b0);
        add_idle(1);
        n = 0; errs = 0; rdy_after = 1'bx; rdy_next = 1'bx;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL load cycle %0d: got %h expected %h", n, obs, exp);
            end
            if (set_err_w === 1'b1) errs++;
            if (n == 6) rdy_after = set_ready_w;
            if (n == 7) rdy_next = set_ready_w;
            n++;
        end
        checks++;
        if (errs != 3 || {hour_w, min_w, sec_w} !== 24'h123456 ||
            rdy_after !== 1'b0 || rdy_next !== 1'b1) begin
            failures++;
            $display("FAIL load_summary: errs=%0d time=%h ready=%b,%b required 3 123456 0,1",
                     errs, {hour_w, min_w, sec_w}, rdy_after, rdy_next);
        end
    endtask

    task automatic test_back_to_back();
        obs_t  exp;
        stim_t st;
        int    n;
        int    busy;
        stim_q.delete();
        stim_q.push_back('{1'b0, 1'b1, 8'h01, 8'h02, 8'h03});
        stim_q.push_back('{1'b0, 1'b1, 8'h04, 8'h05, 8'h06});
        stim_q.push_back('{1'b0, 1'b1, 8'h07, 8'h08, 8'h09});
        stim_q.push_back('{1'b0, 1'b1, 8'h10, 8'h11, 8'h12});
        stim_q.push_back('{1'b0, 1'b1, 8'h13, 8'h14, 8'h15});
        add_idle(1);
        n = 0; busy = 0;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", n, obs, exp);
            end
            if (set_ready_w === 1'b0) busy++;
            n++;
        end
        checks++;
        if (busy != 3 || {hour_w, min_w, sec_w} !== 24'h131415) begin
            failures++;
            $display("FAIL back_to_back_summary: busy=%0d time=%h required 3 131415",
                     busy, {hour_w, min_w, sec_w});
        end
    endtask

    task automatic test_collision();
        obs_t  exp;
        stim_t st;
        int    n;
        int    stb_cnt;
        logic [7:0] sec_before_last;
        stim_q.delete();
        add_load(8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 3; k++) add_pulse(3);
        add_load(8'h10, 8'h20, 8'h30, 1'b1);
        for (int k = 0; k < 4; k++) add_pulse(3);
        n = 0; stb_cnt = 0; sec_before_last = 8'hxx;
        while (stim_q.size() != 0) begin
            st = stim_q.pop_front();
            drive_cycle(st);
            exp = sb_q.pop_front();
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL collision cycle %0d: got %h expected %h", n, obs, exp);
            end
            if (sec_stb_w === 1'b1) stb_cnt++;
            // Index 20 is the cycle after the third post-load pulse.
            if (n == 20) sec_before_last = sec_w;
            n++;
        end
        checks++;
        if (stb_cnt != 1 || sec_before_last !== 8'h30 || {hour_w, min_w, sec_w} !== 24'h102031) begin
            failures++;
            $display("FAIL collision_summary: stb=%0d sec_pre=%h time=%h required 1 30 102031",
                     stb_cnt, sec_before_last, {hour_w, min_w, sec_w});
        end
    endtask

    task automatic test_mid_reset();
        obs_t  exp;
        stim_t st;
        set_valid = 1'b1;
        set_hour  = 8'h05;
        set_min   = 8'h06;
        set_sec   = 8'h07;
        #2;
        reset = 1'b1;
        #1;
        exp = '0;
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_reset_async: got %h expected %h", obs, exp);
        end
        @(negedge clock);
        reset     = 1'b0;
        set_valid = 1'b0;
        model_reset();
        st = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
        drive_cycle(st);
        exp = sb_q.pop_front();
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL mid_reset_release: got %h expected %h", obs, exp);
        end
    endtask

`ifdef BCD_TIME_ALARM_EN
    task automatic test_alarm();
        obs_t  exp;
        stim_t st;
        int    n;
        int    hits_armed;
        int    hits_disarmed;
        alarm_hour = 8'h07;
        alarm_min  = 8'h30;
        hits_armed = 0; hits_disarmed = 0;
        for (int pass = 0; pass < 2; pass++) begin
            alarm_arm = (pass == 0);
            stim_q.delete();
            add_load(8'h07, 8'h29, 8'h59, 1'b0);
            for (int k = 0; k < 4; k++) add_pulse(3);
            n = 0;
            while (stim_q.size() != 0) begin
                st = stim_q.pop_front();
                drive_cycle(st);
                exp = sb_q.pop_front();
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL alarm pass %0d cycle %0d: got %h expected %h", pass, n, obs, exp);
                end
                if (alarm_hit_w === 1'b1) begin
                    if (pass == 0) hits_armed++;
                    else hits_disarmed++;
                end
                n++;
            end
        end
        checks++;
        if (hits_armed != 1 || hits_disarmed != 0) begin
            failures++;
            $display("FAIL alarm_summary: armed=%0d disarmed=%0d required 1 0",
                     hits_armed, hits_disarmed);
        end
        alarm_arm = 1'b0;
    endtask
`endif

    initial begin
        reset      = 1'b1;
        tick       = 1'b0;
        set_valid  = 1'b0;
        set_hour   = 8'h00;
        set_min    = 8'h00;
        set_sec    = 8'h00;
        alarm_hour = 8'h00;
        alarm_min  = 8'h00;
        alarm_arm  = 1'b0;
        model_reset();

        test_reset();
        test_tick_hold();
        test_tick_count();
        test_rollover();
        test_load();
        test_back_to_back();
        test_collision();
`ifdef BCD_TIME_ALARM_EN
        test_alarm();
`endif
        test_mid_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
